// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the memory initiator: FSM state encoding,
// the OKAY response code and default channel widths.
package mem_if_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrReq,
    StWrResp,
    StResp
  } mem_state_e;

  // Response code meaning success; anything else is reported as an error.
  localparam int unsigned RESP_OKAY = 0;

  localparam int unsigned DefAddrWdth = 4;
  localparam int unsigned DefDataWdth = 32;
  localparam int unsigned DefRespWdth = 1;

endpackage

// File: rtl/mem_wdog.sv
// Loadable down-counter with an expiry flag. Held at LOAD_VAL-1 while load is
// high; counts down while en is high; expire is asserted on the last counted cycle.
module mem_wdog #(
  parameter int unsigned CNT_WDTH = 8,
  parameter int unsigned LOAD_VAL = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [CNT_WDTH-1:0] count_q;

  // Reload while idle, then count down to zero and stop there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= CNT_WDTH'(LOAD_VAL - 1);
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - CNT_WDTH'(1);
    end
  end

  assign expire = en && !load && (count_q == '0);

endmodule

// File: rtl/mem_initiator.sv
// Memory-interface initiator: converts single-word client requests into
// AR/R or AW/W/B transactions, one outstanding at a time, and returns the
// response to the client. Every output is driven straight from a register.
// Optional feature: define MEM_INIT_TIMEOUT_EN to bound the response wait
// by TIMEOUT_CYC cycles, with draining of the late beat afterwards.
module mem_initiator
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_WDTH = DefAddrWdth,
  parameter int unsigned DATA_WDTH = DefDataWdth,
  parameter int unsigned RESP_WDTH = DefRespWdth
`ifdef MEM_INIT_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // client request
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_WDTH-1:0] req_addr,
  input  logic [DATA_WDTH-1:0] req_wdata,
  // client response
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_write,
  output logic                 rsp_err,
  output logic [DATA_WDTH-1:0] rsp_rdata,
  // read address / data
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_WDTH-1:0] ar_address,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [RESP_WDTH-1:0] r_resp,
  input  logic [DATA_WDTH-1:0] r_data,
  // write address / data / response
  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic [ADDR_WDTH-1:0] aw_address,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [DATA_WDTH-1:0] w_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [RESP_WDTH-1:0] b_resp
);

  mem_state_e state_q, state_d;

  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic                 write_q, write_d;
  logic [ADDR_WDTH-1:0] addr_q, addr_d;
  logic [DATA_WDTH-1:0] wdata_q, wdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [DATA_WDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic req_ready_q, req_ready_d;
  logic ar_valid_q, ar_valid_d;
  logic r_ready_q, r_ready_d;
  logic aw_valid_q, aw_valid_d;
  logic w_valid_q, w_valid_d;
  logic b_ready_q, b_ready_d;
  logic rsp_valid_q, rsp_valid_d;

`ifdef MEM_INIT_TIMEOUT_EN
  localparam int unsigned CntWdth = $clog2(TIMEOUT_CYC + 1);

  logic drain_q, drain_d;
  logic resp_wait;
  logic wdog_expire;

  // Only the response phases are bounded; address phases cannot be withdrawn.
  assign resp_wait = (state_q == StRdData) || (state_q == StWrResp);

  mem_wdog #(
    .CNT_WDTH(CntWdth),
    .LOAD_VAL(TIMEOUT_CYC)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (!resp_wait),
    .en    (resp_wait),
    .expire(wdog_expire)
  );
`endif

  // Next-state, captured payload and registered-output values.
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef MEM_INIT_TIMEOUT_EN
    drain_d     = drain_q;
    // A late beat on the abandoned channel ends the drain.
    if (drain_q && ((!write_q && r_valid && r_ready_q) || (write_q && b_valid && b_ready_q))) begin
      drain_d = 1'b0;
    end
`endif

    case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          state_d     = req_write ? StWrReq : StRdAddr;
        end
      end
      StRdAddr: begin
        if (ar_valid_q && ar_ready) state_d = StRdData;
      end
      StRdData: begin
        if (r_valid && r_ready_q) begin
          rsp_err_d   = (r_resp != RESP_WDTH'(RESP_OKAY));
          rsp_rdata_d = (r_resp == RESP_WDTH'(RESP_OKAY)) ? r_data : '0;
          state_d     = StResp;
        end
`ifdef MEM_INIT_TIMEOUT_EN
        else if (wdog_expire) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          drain_d     = 1'b1;
          state_d     = StResp;
        end
`endif
      end
      StWrReq: begin
        // AW and W complete independently, possibly in the same cycle.
        if (aw_valid_q && aw_ready) aw_done_d = 1'b1;
        if (w_valid_q && w_ready) w_done_d = 1'b1;
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        if (b_valid && b_ready_q) begin
          rsp_err_d   = (b_resp != RESP_WDTH'(RESP_OKAY));
          rsp_rdata_d = '0;
          state_d     = StResp;
        end
`ifdef MEM_INIT_TIMEOUT_EN
        else if (wdog_expire) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          drain_d     = 1'b1;
          state_d     = StResp;
        end
`endif
      end
      StResp: begin
        if (rsp_valid_q && rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they appear registered.
    req_ready_d = (state_d == StIdle);
    ar_valid_d  = (state_d == StRdAddr);
    r_ready_d   = (state_d == StRdData);
    aw_valid_d  = (state_d == StWrReq) && !aw_done_d;
    w_valid_d   = (state_d == StWrReq) && !w_done_d;
    b_ready_d   = (state_d == StWrResp);
    rsp_valid_d = (state_d == StResp);
`ifdef MEM_INIT_TIMEOUT_EN
    req_ready_d = req_ready_d && !drain_d;
    r_ready_d   = r_ready_d || (drain_d && !write_d);
    b_ready_d   = b_ready_d || (drain_d && write_d);
`endif
  end

  // State, payload and output registers; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      req_ready_q <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef MEM_INIT_TIMEOUT_EN
      drain_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      req_ready_q <= req_ready_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      b_ready_q   <= b_ready_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef MEM_INIT_TIMEOUT_EN
      drain_q     <= drain_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = write_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign ar_valid   = ar_valid_q;
  assign ar_address = addr_q;
  assign r_ready    = r_ready_q;
  assign aw_valid   = aw_valid_q;
  assign aw_address = addr_q;
  assign w_valid    = w_valid_q;
  assign w_data     = wdata_q;
  assign b_ready    = b_ready_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: a delay-programmable responder model,
// a table of single transactions, hand sequences for reset and write-channel
// ordering, and a back-to-back random run against a reference memory.
module tb_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ar_valid, ar_ready;
  logic [3:0]  ar_address;
  logic        r_valid, r_ready;
  logic [0:0]  r_resp;
  logic [31:0] r_data;
  logic        aw_valid, aw_ready;
  logic [3:0]  aw_address;
  logic        w_valid, w_ready;
  logic [31:0] w_data;
  logic        b_valid, b_ready;
  logic [0:0]  b_resp;

  mem_initiator #(
    .ADDR_WDTH(4)
`ifdef MEM_INIT_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .ar_valid  (ar_valid),
    .ar_ready  (ar_ready),
    .ar_address(ar_address),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_resp    (r_resp),
    .r_data    (r_data),
    .aw_valid  (aw_valid),
    .aw_ready  (aw_ready),
    .aw_address(aw_address),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_resp    (b_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int viol  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- responder model (shares rst_n) ----------------
  int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
  logic [0:0]  r_resp_cfg, b_resp_cfg;
  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];

  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic        r_pend, aw_got, w_got;
  logic [3:0]  rd_addr, wr_addr;
  logic [31:0] wr_data;
  logic        ar_valid_p, aw_valid_p, w_valid_p, r_ready_p, b_ready_p, rst_p;
  logic [3:0]  ar_addr_p, aw_addr_p;
  logic [31:0] w_data_p;
  logic        ar_fire, r_fire, aw_fire, w_fire, b_fire;

  // Responder and valid-hold monitor; all handshakes are inferred from values
  // that were stable across the preceding rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      ar_ready = 0; r_valid = 0; r_resp = 0; r_data = 0;
      aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      r_pend = 0; aw_got = 0; w_got = 0;
    end else begin
      if (rst_p) begin
        if (ar_valid_p && !ar_ready && (!ar_valid || ar_address != ar_addr_p)) begin
          viol++;
          $display("FAIL proto_ar: valid=%b addr=%h, required 1/%h (cyc %0d)",
                   ar_valid, ar_address, ar_addr_p, cyc);
        end
        if (aw_valid_p && !aw_ready && (!aw_valid || aw_address != aw_addr_p)) begin
          viol++;
          $display("FAIL proto_aw: valid=%b addr=%h, required 1/%h (cyc %0d)",
                   aw_valid, aw_address, aw_addr_p, cyc);
        end
        if (w_valid_p && !w_ready && (!w_valid || w_data != w_data_p)) begin
          viol++;
          $display("FAIL proto_w: valid=%b data=%h, required 1/%h (cyc %0d)",
                   w_valid, w_data, w_data_p, cyc);
        end
      end
      ar_fire = ar_valid_p && ar_ready;
      r_fire  = r_valid && r_ready_p;
      aw_fire = aw_valid_p && aw_ready;
      w_fire  = w_valid_p && w_ready;
      b_fire  = b_valid && b_ready_p;
      // read address then data
      if (ar_fire) begin
        ar_ready = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0; rd_addr = ar_addr_p;
      end else if (ar_valid && !ar_ready) begin
        if (ar_cnt >= ar_dly) ar_ready = 1; else ar_cnt++;
      end
      if (r_fire) begin
        r_valid = 0; r_pend = 0;
      end
      if (r_pend && !r_valid) begin
        if (r_cnt >= r_dly) begin
          r_valid = 1; r_resp = r_resp_cfg; r_data = mem[rd_addr];
        end else r_cnt++;
      end
      // write address, data and response
      if (aw_fire) begin
        aw_ready = 0; aw_cnt = 0; aw_got = 1; wr_addr = aw_addr_p;
      end else if (aw_valid && !aw_ready && !aw_got) begin
        if (aw_cnt >= aw_dly) aw_ready = 1; else aw_cnt++;
      end
      if (w_fire) begin
        w_ready = 0; w_cnt = 0; w_got = 1; wr_data = w_data_p;
      end else if (w_valid && !w_ready && !w_got) begin
        if (w_cnt >= w_dly) w_ready = 1; else w_cnt++;
      end
      if (b_fire) b_valid = 0;
      if (aw_got && w_got && !b_valid) begin
        if (b_cnt >= b_dly) begin
          b_valid = 1; b_resp = b_resp_cfg; b_cnt = 0;
          if (b_resp_cfg == 0) mem[wr_addr] = wr_data;
          aw_got = 0; w_got = 0;
        end else b_cnt++;
      end
    end
    ar_valid_p = ar_valid; ar_addr_p = ar_address;
    aw_valid_p = aw_valid; aw_addr_p = aw_address;
    w_valid_p  = w_valid;  w_data_p  = w_data;
    r_ready_p  = r_ready;  b_ready_p = b_ready;
    rst_p      = rst_n;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    int          ar_dly;
    int          r_dly;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic        resp;
    int          rsp_dly;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;   // request-accept cycle to rsp_valid cycle; -1 = unchecked
    logic        drain;
  } vec_t;

  vec_t vecs[10];

  // One complete transaction; called and returns just after a falling edge.
  task automatic run_txn(input vec_t v, input string nm);
    int acc_cyc, rsp_cyc;
    logic got, stable, rr_low;
    logic c_err, c_wr;
    logic [31:0] c_rd;
    acc_cyc = 0; rsp_cyc = 0;
    ar_dly = v.ar_dly; r_dly = v.r_dly; aw_dly = v.aw_dly; w_dly = v.w_dly; b_dly = v.b_dly;
    r_resp_cfg = v.resp; b_resp_cfg = v.resp;
    req_valid = 1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      if (req_ready) begin
        got = 1; acc_cyc = cyc;
      end
      @(negedge clk);
    end
    req_valid = 0; req_wdata = 32'h0BAD_0BAD;
    check({nm, " accept"}, {31'b0, got}, 32'd1);
    if (!got) return;
    got = 0; rr_low = 1;
    for (int n = 0; n < 200 && !got; n++) begin
      if (rsp_valid) begin
        got = 1; rsp_cyc = cyc;
      end else begin
        if (req_ready) rr_low = 0;
        @(negedge clk);
      end
    end
    check({nm, " rsp_seen"}, {31'b0, got}, 32'd1);
    if (!got) return;
    check({nm, " err"}, {31'b0, rsp_err}, {31'b0, v.exp_err});
    check({nm, " rdata"}, rsp_rdata, v.exp_rdata);
    check({nm, " write"}, {31'b0, rsp_write}, {31'b0, v.wr});
    if (v.exp_lat >= 0) check({nm, " latency"}, rsp_cyc - acc_cyc, v.exp_lat);
    c_err = rsp_err; c_rd = rsp_rdata; c_wr = rsp_write; stable = 1;
    rsp_ready = 0;
    repeat (v.rsp_dly) begin
      @(negedge clk);
      if (!rsp_valid || rsp_err !== c_err || rsp_rdata !== c_rd || rsp_write !== c_wr) stable = 0;
      if (req_ready) rr_low = 0;
    end
    if (v.rsp_dly > 0) check({nm, " rsp_stable"}, {31'b0, stable}, 32'd1);
    check({nm, " req_ready_low"}, {31'b0, rr_low}, 32'd1);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check({nm, " rsp_drop"}, {31'b0, rsp_valid}, 32'd0);
    check({nm, " idle_ready"}, {31'b0, req_ready}, {31'b0, !v.drain});
    if (v.wr && v.resp == 0 && !v.drain) ref_mem[v.addr] = v.wdata;
  endtask

  initial begin
    vec_t rv;
    logic got;
    // wr addr wdata ard rd awd wd bd resp rspd err rdata lat drain
    vecs[0] = '{1'b1, 4'h3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 32'h0, 3, 1'b0};
    vecs[1] = '{1'b0, 4'h3, 32'h0, 0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 32'hDEADBEEF, 3, 1'b0};
    vecs[2] = '{1'b0, 4'hA, 32'h0, 0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 32'h12345678, 3, 1'b0};
    vecs[3] = '{1'b0, 4'h3, 32'h0, 0, 0, 0, 0, 0, 1'b1, 5, 1'b1, 32'h0, 3, 1'b0};
    vecs[4] = '{1'b1, 4'h5, 32'hCAFEF00D, 0, 0, 3, 0, 2, 1'b0, 0, 1'b0, 32'h0, 8, 1'b0};
    vecs[5] = '{1'b1, 4'h5, 32'h11111111, 0, 0, 0, 0, 0, 1'b1, 0, 1'b1, 32'h0, 3, 1'b0};
    vecs[6] = '{1'b0, 4'h5, 32'h0, 0, 4, 0, 0, 0, 1'b0, 0, 1'b0, 32'hCAFEF00D, 7, 1'b0};
    vecs[7] = '{1'b0, 4'hF, 32'h0, 2, 0, 0, 0, 0, 1'b0, 0, 1'b0, 32'h0, 5, 1'b0};
    vecs[8] = '{1'b1, 4'h0, 32'hFFFFFFFF, 0, 0, 1, 1, 0, 1'b0, 0, 1'b0, 32'h0, 4, 1'b0};
    vecs[9] = '{1'b0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 1'b0, 2, 1'b0, 32'hFFFFFFFF, 3, 1'b0};

    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h0; ref_mem[i] = 32'h0;
    end
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
    r_resp_cfg = 0; b_resp_cfg = 0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;

    // reset state
    rst_n = 0;
    repeat (2) @(negedge clk);
    check("reset req_ready", {31'b0, req_ready}, 32'd0);
    check("reset valids", {25'b0, ar_valid, aw_valid, w_valid, r_ready, b_ready, rsp_valid,
                           rsp_err}, 32'd0);
    check("reset rdata", rsp_rdata, 32'd0);
    check("reset addr", {24'b0, ar_address, aw_address}, 32'd0);
    #2 rst_n = 1;
    @(negedge clk);
    check("post-reset req_ready", {31'b0, req_ready}, 32'd1);

    // write with AW accepted two cycles ahead of W
    aw_dly = 0; w_dly = 2; b_dly = 0; b_resp_cfg = 0;
    req_valid = 1; req_write = 1; req_addr = 4'hA; req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 0;
    check("wr both valid", {30'b0, aw_valid, w_valid}, 32'd3);
    check("wr aw_address", {28'b0, aw_address}, 32'hA);
    @(negedge clk);
    check("wr aw drops alone", {30'b0, aw_valid, w_valid}, 32'd1);
    @(negedge clk);
    check("wr w held", {30'b0, aw_valid, w_valid}, 32'd1);
    check("wr w_data", w_data, 32'h12345678);
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      if (rsp_valid) got = 1; else @(negedge clk);
    end
    check("wr rsp_seen", {31'b0, got}, 32'd1);
    check("wr rsp fields", {30'b0, rsp_write, rsp_err}, 32'd2);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    ref_mem[4'hA] = 32'h12345678;

    // table
    for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // reset while AR waits for ready
    ar_dly = 100;
    req_valid = 1; req_write = 0; req_addr = 4'h2;
    @(negedge clk);
    req_valid = 0;
    check("rst ar_valid before", {31'b0, ar_valid}, 32'd1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("rst async ar_valid", {31'b0, ar_valid}, 32'd0);
    check("rst async req_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    check("rst release req_ready", {31'b0, req_ready}, 32'd1);
    check("rst release ar_valid", {31'b0, ar_valid}, 32'd0);

    // back-to-back random traffic against the reference memory
    for (int i = 0; i < 16; i++) begin
      rv.wr = 1'($urandom_range(0, 1));
      rv.addr = 4'($urandom_range(0, 15));
      rv.wdata = $urandom;
      rv.ar_dly = $urandom_range(0, 2); rv.r_dly = $urandom_range(0, 2);
      rv.aw_dly = $urandom_range(0, 2); rv.w_dly = $urandom_range(0, 2);
      rv.b_dly = $urandom_range(0, 2);
      rv.resp = 1'b0; rv.rsp_dly = $urandom_range(0, 1);
      rv.exp_err = 1'b0;
      rv.exp_rdata = rv.wr ? 32'h0 : ref_mem[rv.addr];
      rv.exp_lat = -1; rv.drain = 1'b0;
      run_txn(rv, $sformatf("rnd%0d", i));
    end

`ifdef MEM_INIT_TIMEOUT_EN
    // B withheld past the limit, then drained
    rv = '{1'b1, 4'h7, 32'hA5A5A5A5, 0, 0, 0, 0, 12, 1'b0, 0, 1'b1, 32'h0, 10, 1'b1};
    run_txn(rv, "timeout");
    check("timeout b_ready drain", {31'b0, b_ready}, 32'd1);
    got = 0;
    for (int n = 0; n < 30 && !got; n++) begin
      if (b_valid) got = 1; else @(negedge clk);
    end
    check("timeout late b", {31'b0, got}, 32'd1);
    check("timeout blocked", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check("timeout drained", {30'b0, req_ready, b_ready}, 32'd2);
    ref_mem[4'h7] = 32'hA5A5A5A5;
    rv = '{1'b0, 4'h7, 32'h0, 0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 32'hA5A5A5A5, 3, 1'b0};
    run_txn(rv, "after_drain");
`endif

    check("protocol violations", viol, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
